pipeline_step_ctrl: RTL

- Sequences the five pipeline registers (PC, IF_ID, ID_EX, EX_MEM, MEM_WB) by driving their per-stage i_step enables and the ID_EX bubble flush.
- Provides debug-unit run, pause and single-step control, load-use stall insertion, and HALT-instruction drain.
- Counts active pipeline cycles for the debug unit.

---
 rtl/pipeline_step_ctrl.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/pipeline_step_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_step_ctrl
//
// Sequences the five pipeline registers (PC, IF_ID, ID_EX, EX_MEM, MEM_WB).
// Debug run/pause/single-step control, load-use stall insertion and
// HALT-instruction drain all meet here. The block also counts cycles in which
// the pipeline was stepped.
//
// The controller state changes on posedge i_clk. The pipeline registers
// capture on the negedge. Step enables are combinational from registered
// state plus the hazard inputs, so they settle in the first half-cycle.
//
// Optional feature: define PIPELINE_STEP_CTRL_BREAKPOINT_EN to add a PC
// breakpoint. That adds ports i_bp_enable, i_bp_addr, i_pc and o_bp_hit.
//
// Ports:
//   i_clk                    system clock
//   i_reset                  async active-high reset
//   i_run_cmd                pulse: start continuous run
//   i_step_cmd               pulse: advance one cycle (only honoured in IDLE)
//   i_halt_cmd               pulse: pause continuous run
//   i_halt_instr             HALT opcode decoded in ID
//   i_idex_mem_read          ID_EX holds a load
//   i_idex_reg_dir_to_write  ID_EX destination register
//   i_ifid_dir_rs/rt         source registers of the instruction in ID
//   i_ifid_uses_rt           instruction in ID reads rt
//   o_*_step                 per-stage step enables
//   o_idex_flush             loads a bubble into ID_EX
//   o_stall                  load-use stall applied this cycle
//   o_state                  IDLE=0, RUN=1, DRAIN=2, HALTED=3
//   o_halted                 high in HALTED
//   o_cycle_count            saturating count of stepped cycles
// -----------------------------------------------------------------------------
module pipeline_step_ctrl #(
   parameter int NB           = 32,
   parameter int NB_REGS      = 5,
   parameter int NB_DRAIN     = 3,
   parameter int DRAIN_CYCLES = 4   // legal range 1 .. 2**NB_DRAIN-1
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_run_cmd,
   input  logic               i_step_cmd,
   input  logic               i_halt_cmd,
   input  logic               i_halt_instr,
   input  logic               i_idex_mem_read,
   input  logic [NB_REGS-1:0] i_idex_reg_dir_to_write,
   input  logic [NB_REGS-1:0] i_ifid_dir_rs,
   input  logic [NB_REGS-1:0] i_ifid_dir_rt,
   input  logic               i_ifid_uses_rt,
`ifdef PIPELINE_STEP_CTRL_BREAKPOINT_EN
   input  logic               i_bp_enable,
   input  logic [NB-1:0]      i_bp_addr,
   input  logic [NB-1:0]      i_pc,
   output logic               o_bp_hit,
`endif
   output logic               o_pc_step,
   output logic               o_ifid_step,
   output logic               o_idex_step,
   output logic               o_exmem_step,
   output logic               o_memwb_step,
   output logic               o_idex_flush,
   output logic               o_stall,
   output logic [1:0]         o_state,
   output logic               o_halted,
   output logic [NB-1:0]      o_cycle_count
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      DRAIN  = 2'd2,
      HALTED = 2'd3
   } state_t;

   localparam logic [NB_DRAIN-1:0] DRAIN_LOAD = NB_DRAIN'(DRAIN_CYCLES - 1);

   state_t              state, state_nxt;
   logic                step_pending, step_pending_nxt;
   logic [NB_DRAIN-1:0] drain_cnt, drain_cnt_nxt;
   logic [NB-1:0]       cycle_count;

   logic active;
   logic hazard;
   logic bp_hit;
   logic any_step;

   // A pipeline cycle is granted in continuous run or for the one cycle
   // that follows an accepted single-step command.
   assign active = (state == RUN) | ((state == IDLE) & step_pending);

   // Load-use hazard: the load in EX writes a register that the instruction
   // in ID reads. Register 0 is never a real dependency.
   assign hazard = i_idex_mem_read
                 & (i_idex_reg_dir_to_write != '0)
                 & ((i_idex_reg_dir_to_write == i_ifid_dir_rs)
                    | (i_ifid_uses_rt & (i_idex_reg_dir_to_write == i_ifid_dir_rt)));

`ifdef PIPELINE_STEP_CTRL_BREAKPOINT_EN
   // The breakpoint only fires in continuous run. A single step from IDLE
   // therefore moves past it. Hazards and HALT keep their own handling.
   assign bp_hit = (state == RUN) & i_bp_enable & (i_pc == i_bp_addr)
                 & ~hazard & ~i_halt_instr;
`else
   assign bp_hit = 1'b0;
`endif

   // -------------------------------------------------------------------------
   // Next state and step enables
   // -------------------------------------------------------------------------
   always_comb begin
      state_nxt        = state;
      step_pending_nxt = 1'b0;       // a pending step lasts one cycle only
      drain_cnt_nxt    = drain_cnt;
      o_pc_step        = 1'b0;
      o_ifid_step      = 1'b0;
      o_idex_step      = 1'b0;
      o_exmem_step     = 1'b0;
      o_memwb_step     = 1'b0;
      o_idex_flush     = 1'b0;
      o_stall          = 1'b0;

      // Enables
      if (active) begin
         if (hazard) begin
            // Hold PC and IF_ID. Insert a bubble in ID_EX and let the load move on.
            o_idex_step  = 1'b1;
            o_exmem_step = 1'b1;
            o_memwb_step = 1'b1;
            o_idex_flush = 1'b1;
            o_stall      = 1'b1;
         end else if (i_halt_instr) begin
            // Freeze fetch. Older instructions keep flowing behind bubbles.
            o_idex_step  = 1'b1;
            o_exmem_step = 1'b1;
            o_memwb_step = 1'b1;
            o_idex_flush = 1'b1;
         end else if (!bp_hit) begin
            o_pc_step    = 1'b1;
            o_ifid_step  = 1'b1;
            o_idex_step  = 1'b1;
            o_exmem_step = 1'b1;
            o_memwb_step = 1'b1;
         end
      end else if (state == DRAIN) begin
         o_idex_step  = 1'b1;
         o_exmem_step = 1'b1;
         o_memwb_step = 1'b1;
         o_idex_flush = 1'b1;
      end

      // Transitions
      unique case (state)
         IDLE: begin
            if (step_pending & ~hazard & i_halt_instr) begin
               // HALT is seen during a single step. The drain then runs on its own.
               state_nxt     = DRAIN;
               drain_cnt_nxt = DRAIN_LOAD;
            end else if (i_run_cmd & ~i_halt_cmd) begin
               state_nxt = RUN;
            end else if (i_step_cmd & ~i_run_cmd) begin
               step_pending_nxt = 1'b1;
            end
         end
         RUN: begin
            if (~hazard & i_halt_instr) begin
               state_nxt     = DRAIN;
               drain_cnt_nxt = DRAIN_LOAD;
            end else if (bp_hit | i_halt_cmd) begin
               state_nxt = IDLE;
            end
         end
         DRAIN: begin
            if (drain_cnt == '0) state_nxt = HALTED;
            else                 drain_cnt_nxt = drain_cnt - 1'b1;
         end
         HALTED: begin
            // Only i_reset leaves this state.
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign any_step = o_pc_step | o_ifid_step | o_idex_step | o_exmem_step | o_memwb_step;

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state        <= IDLE;
         step_pending <= 1'b0;
         drain_cnt    <= '0;
      end else begin
         state        <= state_nxt;
         step_pending <= step_pending_nxt;
         drain_cnt    <= drain_cnt_nxt;
      end
   end

   // Saturating count of cycles in which any stage was stepped.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset)                            cycle_count <= '0;
      else if (any_step && cycle_count != '1) cycle_count <= cycle_count + 1'b1;
   end

`ifdef PIPELINE_STEP_CTRL_BREAKPOINT_EN
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) o_bp_hit <= 1'b0;
      else         o_bp_hit <= bp_hit;
   end
`endif

   assign o_state       = state;
   assign o_halted      = (state == HALTED);
   assign o_cycle_count = cycle_count;

endmodule
